// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: opcodes of interest and FSM encoding.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Index width for an NREQ-wide requester set; never zero.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU among NREQ requesters with round-robin
// grant, registered operands/result, and a one-hot response to the issuing requester.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int OPW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*DW-1:0]  req_op1,
  input  logic [NREQ*DW-1:0]  req_op2,
  input  logic [NREQ*OPW-1:0] req_aluop,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [DW-1:0]     rsp_result,
  output logic              rsp_zero,
  output logic [DW-1:0]     alu_op1,
  output logic [DW-1:0]     alu_op2,
  output logic [OPW-1:0]    alu_op,
  input  logic [DW-1:0]     alu_result,
  input  logic              alu_zero
);

  localparam int IW = idx_w(NREQ);

  state_t          state, nxt;
  logic [IW-1:0]   ptr, owner, gidx;
  logic [NREQ-1:0] grant;
  logic            arb_en, take, rsp_fire;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign arb_en = (state == ST_IDLE) && rst_n;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = grant;
  assign take      = |grant;
  assign rsp_fire  = (state == ST_RESP) && rsp_ready[owner];

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESP) rsp_valid[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (take) nxt = ST_EXEC;
      ST_EXEC: nxt = ST_RESP;
      ST_RESP: if (rsp_fire) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      owner      <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (take) begin
        alu_op1 <= req_op1[gidx*DW +: DW];
        alu_op2 <= req_op2[gidx*DW +: DW];
        alu_op  <= req_aluop[gidx*OPW +: OPW];
        owner   <= gidx;
        ptr     <= (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);
      end
      // Result is captured once and then held until the next grant's EXEC.
      if (state == ST_EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (NREQ=2) with a behavioural ALU on the alu_* side.
module tb_alu_share_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int OPW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*DW-1:0]  req_op1, req_op2;
  logic [NREQ*OPW-1:0] req_aluop;
  logic [DW-1:0]     rsp_result, alu_op1, alu_op2, alu_result;
  logic [OPW-1:0]    alu_op;
  logic              rsp_zero, alu_zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_aluop(req_aluop),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Reference ALU: ADD/SUB/AND/OR, anything else yields 0 with Zero set.
  always_comb begin
    case (alu_op)
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op1[r*DW +: DW]    = a;
    req_op2[r*DW +: DW]    = b;
    req_aluop[r*OPW +: OPW] = op;
  endtask

  // Full single-requester transaction; entered and left at a negedge with the DUT idle.
  task automatic do_op(input string tag, input int r, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez);
    logic [1:0] oh;
    oh = 2'(1 << r);
    set_req(r, op, a, b);
    req_valid = oh;
    #1 chk({tag, " ready c0"}, 64'(req_ready), 64'(oh));
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    chk({tag, " no rsp c1"}, 64'(rsp_valid), 64'h0);
    @(posedge clk); @(negedge clk);
    chk({tag, " rsp_valid c2"}, 64'(rsp_valid), 64'(oh));
    chk({tag, " result"}, 64'(rsp_result), 64'(er));
    chk({tag, " zero"}, 64'(rsp_zero), 64'(ez));
    rsp_ready = oh;
    @(posedge clk); @(negedge clk);
    rsp_ready = '0;
    chk({tag, " rsp done"}, 64'(rsp_valid), 64'h0);
  endtask

  initial begin
    // 1: reset with random inputs
    rst_n     = 1'b0;
    req_valid = 2'($urandom);
    rsp_ready = 2'($urandom);
    req_op1   = {$urandom, $urandom};
    req_op2   = {$urandom, $urandom};
    req_aluop = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst req_ready", 64'(req_ready), 64'h0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst rsp_result", 64'(rsp_result), 64'h0);
    chk("rst rsp_zero", 64'(rsp_zero), 64'h0);
    chk("rst alu_op1", 64'(alu_op1), 64'h0);
    chk("rst alu_op2", 64'(alu_op2), 64'h0);
    chk("rst alu_op", 64'(alu_op), 64'h0);
    req_valid = '0;
    rsp_ready = '0;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle req_ready", 64'(req_ready), 64'h0);
    chk("idle rsp_valid", 64'(rsp_valid), 64'h0);

    // 2/3: single ops, wrap and unsupported opcode
    do_op("add 5+7", 0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0);
    do_op("sub 9-9", 0, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1);
    do_op("add wrap", 0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    do_op("sub 0-1", 0, 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    // Served from requester 1 so the pointer wraps back to 0 for the contention run.
    do_op("op 1111", 1, 4'b1111, 32'd77, 32'd5, 32'd0, 1'b1);

    // 4: contention, both valid, expect 0,1,0,1
    set_req(0, 4'b0010, 32'd1, 32'd1);
    set_req(1, 4'b0010, 32'd3, 32'd3);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("cont grant %0d", i), 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
      @(posedge clk); @(negedge clk);
      chk($sformatf("cont exec %0d", i), 64'(rsp_valid), 64'h0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("cont rsp %0d", i), 64'(rsp_valid), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk($sformatf("cont res %0d", i), 64'(rsp_result), (i % 2 == 0) ? 64'd2 : 64'd6);
      @(posedge clk); @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = '0;

    // 5: backpressure on requester 1 while requester 0 waits
    set_req(1, 4'b0110, 32'd10, 32'd3);
    req_valid = 2'b10;
    #1 chk("bp grant1", 64'(req_ready), 64'h2);
    @(posedge clk); @(negedge clk);
    set_req(0, 4'b0010, 32'd100, 32'd23);
    req_valid = 2'b01;
    chk("bp exec ready", 64'(req_ready), 64'h0);
    @(posedge clk); @(negedge clk);
    rsp_ready = 2'b01;  // non-owner ready must be ignored
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp hold vld %0d", i), 64'(rsp_valid), 64'h2);
      chk($sformatf("bp hold res %0d", i), 64'(rsp_result), 64'd7);
      chk($sformatf("bp hold rdy %0d", i), 64'(req_ready), 64'h0);
      chk($sformatf("bp hold op1 %0d", i), 64'(alu_op1), 64'd10);
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(posedge clk); @(negedge clk);
    rsp_ready = '0;
    #1 chk("bp req0 grant", 64'(req_ready), 64'h1);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    chk("bp req0 rsp", 64'(rsp_valid), 64'h1);
    chk("bp req0 res", 64'(rsp_result), 64'd123);
    rsp_ready = 2'b01;
    @(posedge clk); @(negedge clk);
    rsp_ready = '0;

    // 6: reset in EXEC drops the op and resets the pointer to requester 0
    set_req(0, 4'b0010, 32'd4, 32'd4);
    req_valid = 2'b01;
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1 chk("midrst rsp_valid", 64'(rsp_valid), 64'h0);
    chk("midrst alu_op1", 64'(alu_op1), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("midrst no rsp", 64'(rsp_valid), 64'h0);
    end
    set_req(1, 4'b0010, 32'd3, 32'd3);
    req_valid = 2'b11;
    #1 chk("midrst grant0", 64'(req_ready), 64'h1);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    chk("midrst rsp0", 64'(rsp_valid), 64'h1);
    chk("midrst res", 64'(rsp_result), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
